// File: rtl/vote_pkg.sv
// Shared types and defaults for the voting front end.
// State encoding, timing defaults and a ballot popcount helper.
package vote_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPEN   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int DEF_DEB_CYCLES = 1000000;
   localparam int DEF_WIN_CYCLES = 250000000;
   localparam int DEF_CNT_W      = 28;

   function automatic logic [1:0] pop3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/vote_capture_debounce.sv
// Debouncer for one raw active-low key: sync, stability counter,
// stable level and a one-cycle press pulse on the 1->0 change.
module key_debounce
   import vote_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_diff;
   logic             w_done;

   assign w_diff  = (r_sync2 != r_stable);
   assign w_done  = (r_cnt == CNT_W'(DEB_CYCLES - 1));
   assign o_press = r_press;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_press  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
            // only a release->press change produces a pulse
            r_press  <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vote_capture.sv
// Voting session front end: five debounced keys, session FSM,
// held ballots and window timeout feeding the majority voter.
module vote_capture
   import vote_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int WIN_CYCLES = DEF_WIN_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic       CLK_50M,
   input  logic       RST,
   input  logic       KEY_A,
   input  logic       KEY_B,
   input  logic       KEY_C,
   input  logic       KEY_START,
   input  logic       KEY_CLR,
   output logic       VOTE_A,
   output logic       VOTE_B,
   output logic       VOTE_C,
   output logic       VOTE_VALID,
   output logic       VOTE_DONE,
   output logic       SESSION_OPEN,
   output logic [1:0] VOTED_CNT
);

   logic [4:0]       w_keys_n;
   logic [4:0]       w_press;
   logic [2:0]       w_new;
   logic [1:0]       w_sum;
   logic             w_tmo;

   state_t           r_state;
   logic [2:0]       r_ballot;
   logic [1:0]       r_cnt;
   logic [CNT_W-1:0] r_win;
   logic             r_done;

   assign w_keys_n = {KEY_CLR, KEY_START, KEY_C, KEY_B, KEY_A};

   for (genvar g = 0; g < 5; g++) begin : g_deb
      key_debounce #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W)
      ) u_deb (
         .i_clk   (CLK_50M),
         .i_rst   (RST),
         .i_key_n (w_keys_n[g]),
         .o_press (w_press[g])
      );
   end

   // repeat presses on an already-set ballot contribute nothing
   assign w_new = w_press[2:0] & ~r_ballot;
   assign w_sum = r_cnt + pop3(w_new);
   assign w_tmo = (r_win == CNT_W'(WIN_CYCLES - 1));

   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_ballot <= '0;
         r_cnt    <= '0;
         r_win    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_press[4]) begin
            r_state  <= ST_IDLE;
            r_ballot <= '0;
            r_cnt    <= '0;
            r_win    <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_press[3]) begin
                     r_state  <= ST_OPEN;
                     r_ballot <= '0;
                     r_cnt    <= '0;
                     r_win    <= '0;
                  end
               end
               ST_OPEN: begin
                  r_ballot <= r_ballot | w_new;
                  r_cnt    <= w_sum;
                  r_win    <= r_win + 1'b1;
                  if (w_sum == 2'd3 || w_tmo) begin
                     r_state <= ST_LOCKED;
                     r_done  <= 1'b1;
                  end
               end
               ST_LOCKED: begin
                  r_state <= ST_LOCKED;
               end
               default: begin
                  r_state  <= ST_IDLE;
                  r_ballot <= '0;
                  r_cnt    <= '0;
                  r_win    <= '0;
               end
            endcase
         end
      end
   end

   assign VOTE_A       = r_ballot[0];
   assign VOTE_B       = r_ballot[1];
   assign VOTE_C       = r_ballot[2];
   assign VOTED_CNT    = r_cnt;
   assign VOTE_DONE    = r_done;
   assign SESSION_OPEN = (r_state == ST_OPEN);
   assign VOTE_VALID   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_vote_capture.sv
// Scoreboard bench for vote_capture with short debounce and window.
// Expected output words are queued at stimulus time and popped at sample time.
module tb_vote_capture;

   localparam int DEB = 4;
   localparam int WIN = 64;

   localparam logic [4:0] M_A   = 5'b00001;
   localparam logic [4:0] M_B   = 5'b00010;
   localparam logic [4:0] M_C   = 5'b00100;
   localparam logic [4:0] M_ST  = 5'b01000;
   localparam logic [4:0] M_CLR = 5'b10000;

   typedef struct {
      string      nm;
      logic [7:0] v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] keys = 5'b11111;
   logic       vote_a, vote_b, vote_c;
   logic       vote_valid, vote_done, session_open;
   logic [1:0] voted_cnt;
   logic [7:0] w_obs;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   vote_capture #(
      .DEB_CYCLES (DEB),
      .WIN_CYCLES (WIN),
      .CNT_W      (28)
   ) dut (
      .CLK_50M      (clk),
      .RST          (rst),
      .KEY_A        (keys[0]),
      .KEY_B        (keys[1]),
      .KEY_C        (keys[2]),
      .KEY_START    (keys[3]),
      .KEY_CLR      (keys[4]),
      .VOTE_A       (vote_a),
      .VOTE_B       (vote_b),
      .VOTE_C       (vote_c),
      .VOTE_VALID   (vote_valid),
      .VOTE_DONE    (vote_done),
      .SESSION_OPEN (session_open),
      .VOTED_CNT    (voted_cnt)
   );

   assign w_obs = {session_open, vote_valid, vote_done,
                   vote_a, vote_b, vote_c, voted_cnt};

   function automatic logic [7:0] mk(input bit o, input bit v,
                                     input bit d, input bit a,
                                     input bit b, input bit c,
                                     input bit [1:0] n);
      return {o, v, d, a, b, c, n};
   endfunction

   task automatic push(input string nm, input logic [7:0] v);
      exp_t t;
      t.nm = nm;
      t.v  = v;
      sb.push_back(t);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [4:0] m, input int n);
      keys = keys & ~m;
      tick(n);
      keys = keys | m;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      push("rst_hold", mk(0, 0, 0, 0, 0, 0, 0));
      tick(2);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      rst = 1'b0;
      push("rst_rel", mk(0, 0, 0, 0, 0, 0, 0));
      tick(1);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
   endtask

   task automatic test_start;
      keys = keys & ~M_ST;
      push("start_lat", mk(0, 0, 0, 0, 0, 0, 0));
      push("start_open", mk(1, 0, 0, 0, 0, 0, 0));
      tick(DEB + 2);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(1);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(3);
      keys = keys | M_ST;
   endtask

   task automatic test_timeout;
      keys = keys & ~M_A;
      push("vote_a", mk(1, 0, 0, 1, 0, 0, 1));
      tick(7);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(3);
      keys = keys | M_A;
      tick(8);
      push("vote_c", mk(1, 0, 0, 1, 0, 1, 2));
      hold(M_C, 10);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      push("pre_tmo", mk(1, 0, 0, 1, 0, 1, 2));
      tick(WIN - 32);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      push("tmo_done", mk(0, 1, 1, 1, 0, 1, 2));
      push("tmo_hold", mk(0, 1, 0, 1, 0, 1, 2));
      tick(1);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(1);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
   endtask

   task automatic test_simultaneous;
      push("clr_idle", mk(0, 0, 0, 0, 0, 0, 0));
      hold(M_CLR, 10);
      tick(8);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      push("reopen", mk(1, 0, 0, 0, 0, 0, 0));
      hold(M_ST, 10);
      tick(8);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      keys = keys & ~(M_A | M_B | M_C);
      push("abc_pre", mk(1, 0, 0, 0, 0, 0, 0));
      push("abc_lock", mk(0, 1, 1, 1, 1, 1, 3));
      tick(DEB + 2);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(1);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(3);
      keys = keys | M_A | M_B | M_C;
      tick(8);
      push("lock_start", mk(0, 1, 0, 1, 1, 1, 3));
      hold(M_ST | M_A, 10);
      tick(8);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
   endtask

   task automatic test_bounce;
      hold(M_CLR, 10);
      tick(8);
      push("bnc_open", mk(1, 0, 0, 0, 0, 0, 0));
      hold(M_ST, 10);
      tick(8);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      push("bnc_reject", mk(1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) begin
         hold(M_B, DEB - 1);
         tick(2);
      end
      tick(4);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      keys = keys & ~M_B;
      push("bnc_solid", mk(1, 0, 0, 0, 1, 0, 1));
      tick(7);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(3);
      keys = keys | M_B;
   endtask

   task automatic test_clr_start;
      keys = keys & ~(M_CLR | M_ST);
      push("cs_pre", mk(1, 0, 0, 0, 1, 0, 1));
      push("cs_idle", mk(0, 0, 0, 0, 0, 0, 0));
      tick(DEB + 2);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(1);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(3);
      keys = keys | M_CLR | M_ST;
      push("cs_stay", mk(0, 0, 0, 0, 0, 0, 0));
      tick(8);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
   endtask

   task automatic test_reset_locked;
      hold(M_ST, 10);
      tick(8);
      keys = keys & ~(M_A | M_B | M_C);
      push("rl_locked", mk(0, 1, 1, 1, 1, 1, 3));
      tick(7);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      tick(3);
      keys = keys | M_A | M_B | M_C;
      tick(8);
      rst = 1'b1;
      push("rl_rst", mk(0, 0, 0, 0, 0, 0, 0));
      tick(1);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
      rst = 1'b0;
      push("rl_idle_a", mk(0, 0, 0, 0, 0, 0, 0));
      hold(M_A, 10);
      tick(8);
      e = sb.pop_front(); n_tests++;
      if (w_obs !== e.v) begin
         n_fail++;
         $display("FAIL %s got %b want %b", e.nm, w_obs, e.v);
      end
   endtask

   initial begin
      tick(1);
      test_reset();
      test_start();
      test_timeout();
      test_simultaneous();
      test_bounce();
      test_clr_start();
      test_reset_locked();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got %0d left want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
